muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 24-bit multiply/divide unit for the single-cycle CPU datapath.
- Consumes the two register-file read operands (ReadRS/ReadRT values) and a destination index.
- Computes the result over a fixed multi-cycle sequence, stalling the core via Busy.
- Produces the register-file write port signals (RD, WriteData, RegWrite) for one cycle on completion.
- Keeps the upper product half, or the remainder, in a local Hi register.

## Interface
- DATA_W, 24: operand/result width; only 24 is supported.
- REG_AW, 4: register index width.

- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high.
- Start  in  1  request; sampled only when Busy=0.
- Op  in  2  operation: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed).
- OpA  in  DATA_W  multiplicand or dividend (RS value).
- OpB  in  DATA_W  multiplier or divisor (RT value).
- DestReg  in  REG_AW  destination register index.
- Busy  out  1  operation in flight; core stalls.
- Done  out  1  one-cycle completion pulse.
- RegWrite  out  1  register-file write enable; one cycle, coincident with Done.
- RD  out  REG_AW  write index, latched at accept.
- WriteData  out  DATA_W  product low half or quotient.
- Hi  out  DATA_W  product high half or remainder; holds until the next completion.
- DivByZero  out  1  set with Done when a divide had OpB=0; cleared at the next accept.

## Operation
- FSM states:
  - IDLE: Start=1 accepts the request. Latches Op, OpA, OpB and DestReg, takes operand magnitudes for signed ops, clears the iteration counter, and goes to CALC.
  - CALC: exactly 24 cycles, one bit per cycle. Multiply uses shift-add into a 48-bit accumulator. Divide uses restoring shift-subtract. Then goes to FIX.
  - FIX: 1 cycle. Applies sign correction and the divide-by-zero override, then goes to WB.
  - WB: 1 cycle. RegWrite=Done=1, WriteData/Hi/RD valid. Then goes to IDLE.
- Operands are latched at accept; later changes on OpA, OpB or DestReg have no effect.
- Arithmetic rules:
  - MULU: 48-bit unsigned product. Low 24 bits go to WriteData, high 24 bits to Hi.
  - MUL: product of magnitudes, negated as 48 bits when the operand signs differ.
  - DIVU: quotient to WriteData, remainder to Hi.
  - DIV: truncating division. Quotient is negative when the signs differ; remainder takes the sign of the dividend.
  - DIV of 0x800000 by 0xFFFFFF: quotient 0x800000 (wraps), remainder 0.
- Divide by zero (DIVU or DIV):
  - Latency unchanged.
  - WriteData=0xFFFFFF, Hi=OpA (original value), DivByZero=1.
  - Register write still occurs.
- DestReg=0 is written like any other index.
- Start while Busy=1 is ignored. Start during WB is ignored.

## Timing
- Start sampled at edge E0:
  - Busy=1 from E0 through E26.
  - CALC occupies E1..E24 and FIX ends at E25.
  - WB cycle lies between E25 and E26: RegWrite=Done=1 and the outputs are valid.
  - The register file captures the result at E26.
  - Busy=0 after E26; the earliest next accept is E27.
- Busy, Done and RegWrite are registered outputs; there is no combinational path from Start.
- WriteData, RD and Hi hold their values after WB until the next WB.
- Reset values: Busy=0, Done=0, RegWrite=0, RD=0, WriteData=0, Hi=0, DivByZero=0, state IDLE.
- Reset asserted mid-operation: the in-flight operation is abandoned with no RegWrite, and all outputs return to their reset values at the next edge.
- Reset has priority over Start in the same cycle.

## Configuration
- MULDIV_DIV_EN defined: all four ops are supported as above.
- MULDIV_DIV_EN undefined:
  - No divider hardware is built.
  - Start with Op[1]=1 is not accepted: Busy stays 0, and there is no Done or RegWrite.
  - DivByZero is tied to 0.
  - Multiply behaviour and timing are unchanged.

## Test plan
- MULU with OpA=0x000003, OpB=0x000005, DestReg=7 -> Busy for 27 cycles; WB cycle has RegWrite=1, RD=7, WriteData=0x00000F, Hi=0x000000.
- MUL with OpA=0xFFFFFE, OpB=0x000003 -> WriteData=0xFFFFFA, Hi=0xFFFFFF.
- DIV with OpA=0xFFFFF9 (-7), OpB=0x000002 -> WriteData=0xFFFFFD, Hi=0xFFFFFF.
- DIVU with OpA=0x000064, OpB=0 -> WriteData=0xFFFFFF, Hi=0x000064, DivByZero=1, latency unchanged.
- Accept a MULU, pulse Start with new operands at cycle 5, then assert Reset at cycle 10:
  - The cycle-5 Start is ignored.
  - Reset causes no RegWrite.
  - All outputs are 0 the cycle after Reset.
  - The next Start is accepted normally.
- Build without MULDIV_DIV_EN, Start with Op=10 -> Busy, Done and RegWrite stay 0; a subsequent MULU completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 24-bit multiply/divide; divider built only when MULDIV_DIV_EN is defined.
// Result is written back 25 edges after accept and Busy drops one edge later; Start is ignored unless idle.
module muldiv_unit #(
    parameter int DATA_W = 24,
    parameter int REG_AW = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [DATA_W-1:0] OpA,
    input  logic [DATA_W-1:0] OpB,
    input  logic [REG_AW-1:0] DestReg,
    output logic              Busy,
    output logic              Done,
    output logic              RegWrite,
    output logic [REG_AW-1:0] RD,
    output logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] Hi,
    output logic              DivByZero
);

    localparam int CW = $clog2(DATA_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] acc_nxt;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W-1:0]   mag_a_in;
    logic [DATA_W-1:0]   mag_b_in;
    logic [DATA_W-1:0]   res_lo;
    logic [DATA_W-1:0]   res_hi;
    logic [REG_AW-1:0]   dest_q;
    logic                neg_q;
    logic                op_ok;
    logic                accept;

`ifdef MULDIV_DIV_EN
    logic                is_div_q;
    logic                neg_r_q;
    logic                zero_q;
    logic                dbz_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W:0]     trial;

    assign op_ok     = 1'b1;
    assign DivByZero = dbz_q;
`else
    assign op_ok     = ~Op[1];
    assign DivByZero = 1'b0;
`endif

    assign accept   = (state == S_IDLE) && Start && op_ok;
    assign mag_a_in = (Op[0] && OpA[DATA_W-1]) ? -OpA : OpA;
    assign mag_b_in = (Op[0] && OpB[DATA_W-1]) ? -OpB : OpB;

    // acc = {partial product | remainder, multiplier | dividend->quotient}
    always_comb begin
        sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, mag_b};
        acc_nxt = acc[0] ? {sum, acc[DATA_W-1:1]} : {1'b0, acc[2*DATA_W-1:1]};
`ifdef MULDIV_DIV_EN
        trial = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]} - {1'b0, mag_b};
        if (is_div_q) begin
            acc_nxt = trial[DATA_W] ? {acc[2*DATA_W-2:0], 1'b0}
                                    : {trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
        end
`endif
    end

    always_comb begin
        prod   = neg_q ? -acc : acc;
        res_lo = prod[DATA_W-1:0];
        res_hi = prod[2*DATA_W-1:DATA_W];
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
            if (zero_q) begin
                res_lo = '1;
                res_hi = a_q;
            end else begin
                res_lo = neg_q   ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
                res_hi = neg_r_q ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
            end
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mag_b     <= '0;
            dest_q    <= '0;
            neg_q     <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
            Hi        <= '0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_r_q   <= 1'b0;
            zero_q    <= 1'b0;
            dbz_q     <= 1'b0;
            a_q       <= '0;
`endif
        end else begin
            Done     <= 1'b0;
            RegWrite <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state  <= S_CALC;
                        Busy   <= 1'b1;
                        cnt    <= '0;
                        acc    <= {{DATA_W{1'b0}}, mag_a_in};
                        mag_b  <= mag_b_in;
                        dest_q <= DestReg;
                        neg_q  <= Op[0] & (OpA[DATA_W-1] ^ OpB[DATA_W-1]);
`ifdef MULDIV_DIV_EN
                        is_div_q <= Op[1];
                        neg_r_q  <= Op[0] & OpA[DATA_W-1];
                        zero_q   <= (OpB == '0);
                        a_q      <= OpA;
                        dbz_q    <= 1'b0;
`endif
                    end
                end
                S_CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state     <= S_WB;
                    Done      <= 1'b1;
                    RegWrite  <= 1'b1;
                    RD        <= dest_q;
                    WriteData <= res_lo;
                    Hi        <= res_hi;
`ifdef MULDIV_DIV_EN
                    dbz_q     <= is_div_q & zero_q;
`endif
                end
                S_WB: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected write-backs, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_muldiv_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [1:0]  Op;
    logic [23:0] OpA;
    logic [23:0] OpB;
    logic [3:0]  DestReg;
    logic        Busy;
    logic        Done;
    logic        RegWrite;
    logic [3:0]  RD;
    logic [23:0] WriteData;
    logic [23:0] Hi;
    logic        DivByZero;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0]  rd;
        logic [23:0] wd;
        logic [23:0] hi;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    muldiv_unit dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .OpA       (OpA),
        .OpB       (OpB),
        .DestReg   (DestReg),
        .Busy      (Busy),
        .Done      (Done),
        .RegWrite  (RegWrite),
        .RD        (RD),
        .WriteData (WriteData),
        .Hi        (Hi),
        .DivByZero (DivByZero)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge Clock) begin
        if (Done || RegWrite) begin
            if (exp_q.size() == 0) begin
                check("unexpected_writeback", 48'({Done, RegWrite}), 48'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_done",      48'(Done),      48'(1));
                check("wb_regwrite",  48'(RegWrite),  48'(1));
                check("wb_rd",        48'(RD),        48'(mon_e.rd));
                check("wb_writedata", 48'(WriteData), 48'(mon_e.wd));
                check("wb_hi",        48'(Hi),        48'(mon_e.hi));
                check("wb_divbyzero", 48'(DivByZero), 48'(mon_e.dbz));
                check("wb_cycle",     48'(cyc),       48'(mon_e.due));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},     48'(Busy),      48'(0));
        check({tag, "_done"},     48'(Done),      48'(0));
        check({tag, "_regwrite"}, 48'(RegWrite),  48'(0));
        check({tag, "_rd"},       48'(RD),        48'(0));
        check({tag, "_wd"},       48'(WriteData), 48'(0));
        check({tag, "_hi"},       48'(Hi),        48'(0));
        check({tag, "_dbz"},      48'(DivByZero), 48'(0));
    endtask

    // Issue one op from an idle negedge; poke=1 pulses a conflicting Start at cycle 5 of the operation.
    task automatic issue(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b,
                         input logic [3:0] d, input logic [23:0] wd, input logic [23:0] hi,
                         input logic dbz, input logic poke);
        exp_t e;
        Op = op; OpA = a; OpB = b; DestReg = d; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0; OpA = ~a; OpB = b ^ 24'h5A5A5A; DestReg = ~d;
        check("busy_after_accept", 48'(Busy), 48'(1));
        check("dbz_clear_at_accept", 48'(DivByZero), 48'(0));
        e.rd = d; e.wd = wd; e.hi = hi; e.dbz = dbz; e.due = cyc + 25;
        exp_q.push_back(e);
        for (int i = 0; i < 40 && Busy; i++) begin
            Start = poke && (i == 4);
            if (Start) begin
                Op = 2'b00; OpA = 24'h00000F; OpB = 24'h0000F0; DestReg = 4'd9;
            end
            @(negedge Clock);
        end
        Start = 1'b0;
        check("busy_fall_cycle", 48'(cyc), 48'(e.due + 1));
        @(negedge Clock);
        check("hold_wd",  48'(WriteData), 48'(wd));
        check("hold_hi",  48'(Hi),        48'(hi));
        check("hold_rd",  48'(RD),        48'(d));
        check("hold_dbz", 48'(DivByZero), 48'(dbz));
    endtask

    task automatic reject(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b);
        logic seen;
        Op = op; OpA = a; OpB = b; DestReg = 4'd5; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check("reject_busy_now", 48'(Busy), 48'(0));
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            seen = seen | Busy;
            @(negedge Clock);
        end
        check("reject_busy_ever", 48'(seen), 48'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Start = 1'b1; Op = 2'b00; OpA = 24'h3; OpB = 24'h5; DestReg = 4'd1;
        repeat (3) @(negedge Clock);
        check_reset_outputs("reset");
        Reset = 1'b0; Start = 1'b0;
        @(negedge Clock);
        check("reset_beats_start", 48'(Busy), 48'(0));

        issue(2'b00, 24'h000003, 24'h000005, 4'd7,  24'h00000F, 24'h000000, 1'b0, 1'b0);
        issue(2'b01, 24'hFFFFFE, 24'h000003, 4'd0,  24'hFFFFFA, 24'hFFFFFF, 1'b0, 1'b0);
        issue(2'b00, 24'hFFFFFF, 24'hFFFFFF, 4'd15, 24'h000001, 24'hFFFFFE, 1'b0, 1'b0);
        issue(2'b01, 24'h800000, 24'h800000, 4'd2,  24'h000000, 24'h400000, 1'b0, 1'b0);
        issue(2'b01, 24'h000007, 24'hFFFFFD, 4'd4,  24'hFFFFEB, 24'hFFFFFF, 1'b0, 1'b1);
        issue(2'b00, 24'h001234, 24'h000100, 4'd6,  24'h123400, 24'h000000, 1'b0, 1'b1);

`ifdef MULDIV_DIV_EN
        issue(2'b11, 24'hFFFFF9, 24'h000002, 4'd3,  24'hFFFFFD, 24'hFFFFFF, 1'b0, 1'b0);
        issue(2'b10, 24'h000064, 24'h000000, 4'd8,  24'hFFFFFF, 24'h000064, 1'b1, 1'b0);
        issue(2'b10, 24'h000064, 24'h000007, 4'd9,  24'h00000E, 24'h000002, 1'b0, 1'b0);
        issue(2'b11, 24'h800000, 24'hFFFFFF, 4'd10, 24'h800000, 24'h000000, 1'b0, 1'b0);
        issue(2'b11, 24'h000007, 24'hFFFFFE, 4'd11, 24'hFFFFFD, 24'h000001, 1'b0, 1'b0);
        issue(2'b11, 24'hFFFFFF, 24'h000000, 4'd12, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0);
        issue(2'b10, 24'hFFFFFF, 24'h000010, 4'd13, 24'h0FFFFF, 24'h00000F, 1'b0, 1'b0);
`else
        reject(2'b10, 24'h000064, 24'h000000);
        reject(2'b11, 24'hFFFFF9, 24'h000002);
        issue(2'b00, 24'h000003, 24'h000005, 4'd7, 24'h00000F, 24'h000000, 1'b0, 1'b0);
`endif

        // Abort: accept, ignored Start at cycle 5, Reset at cycle 10, nothing written back.
        Op = 2'b00; OpA = 24'h000123; OpB = 24'h000456; DestReg = 4'd3; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check("abort_busy", 48'(Busy), 48'(1));
        repeat (4) @(negedge Clock);
        OpA = 24'h000011; OpB = 24'h000022; DestReg = 4'd14; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        check("abort_busy_after_poke", 48'(Busy), 48'(1));
        repeat (4) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check_reset_outputs("abort");
        Reset = 1'b0;
        repeat (30) @(negedge Clock);
        check("abort_stays_idle", 48'(Busy), 48'(0));

        issue(2'b00, 24'h000010, 24'h000020, 4'd1, 24'h000200, 24'h000000, 1'b0, 1'b0);

        repeat (3) @(negedge Clock);
        check("queue_drained", 48'(exp_q.size()), 48'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
